// File: rtl/ir_carrier_gen.sv
// IR carrier, carrier strobe and packet strobe generator with per-packet car/direction snapshot.
// Define IR_CARRIER_DUTY33_EN for ~33% carrier duty; the default build gives 50% (floor).
module ir_carrier_gen #(
  parameter int unsigned CAR0_PERIOD    = 2500,
  parameter int unsigned CAR1_PERIOD    = 2778,
  parameter int unsigned CAR2_PERIOD    = 2667,
  parameter int unsigned CAR3_PERIOD    = 2500,
  parameter int unsigned CAR_CNT_WIDTH  = 12,
  parameter int unsigned PACK_PERIOD    = 10_000_000,
  parameter int unsigned PACK_CNT_WIDTH = 24
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       en,
  input  logic [1:0] car_sel,
  input  logic [3:0] dir_in,
  output logic       Pulse,
  output logic       Pulse_Strobe,
  output logic       pack_strobe,
  output logic [3:0] current_dir_state,
  output logic [1:0] car_id
);

  localparam longint unsigned CarLimit  = 64'd1 << CAR_CNT_WIDTH;
  localparam longint unsigned PackLimit = 64'd1 << PACK_CNT_WIDTH;

  function automatic bit periodBad(input int unsigned per);
    return (per < 3) || (64'(per) > CarLimit) || (PACK_PERIOD <= per);
  endfunction

  generate
    if (periodBad(CAR0_PERIOD) || periodBad(CAR1_PERIOD) || periodBad(CAR2_PERIOD) ||
        periodBad(CAR3_PERIOD) || (64'(PACK_PERIOD) > PackLimit)) begin : gParamCheck
      $error("ir_carrier_gen: illegal carrier/packet period parameters");
    end
  endgenerate

  localparam logic [CAR_CNT_WIDTH-1:0]  LAST0 = CAR_CNT_WIDTH'(CAR0_PERIOD - 1);
  localparam logic [CAR_CNT_WIDTH-1:0]  LAST1 = CAR_CNT_WIDTH'(CAR1_PERIOD - 1);
  localparam logic [CAR_CNT_WIDTH-1:0]  LAST2 = CAR_CNT_WIDTH'(CAR2_PERIOD - 1);
  localparam logic [CAR_CNT_WIDTH-1:0]  LAST3 = CAR_CNT_WIDTH'(CAR3_PERIOD - 1);
  localparam logic [PACK_CNT_WIDTH-1:0] PACK_LAST = PACK_CNT_WIDTH'(PACK_PERIOD - 1);

`ifdef IR_CARRIER_DUTY33_EN
  localparam logic [CAR_CNT_WIDTH-1:0] HIGH0 = CAR_CNT_WIDTH'(CAR0_PERIOD / 3);
  localparam logic [CAR_CNT_WIDTH-1:0] HIGH1 = CAR_CNT_WIDTH'(CAR1_PERIOD / 3);
  localparam logic [CAR_CNT_WIDTH-1:0] HIGH2 = CAR_CNT_WIDTH'(CAR2_PERIOD / 3);
  localparam logic [CAR_CNT_WIDTH-1:0] HIGH3 = CAR_CNT_WIDTH'(CAR3_PERIOD / 3);
`else
  localparam logic [CAR_CNT_WIDTH-1:0] HIGH0 = CAR_CNT_WIDTH'(CAR0_PERIOD >> 1);
  localparam logic [CAR_CNT_WIDTH-1:0] HIGH1 = CAR_CNT_WIDTH'(CAR1_PERIOD >> 1);
  localparam logic [CAR_CNT_WIDTH-1:0] HIGH2 = CAR_CNT_WIDTH'(CAR2_PERIOD >> 1);
  localparam logic [CAR_CNT_WIDTH-1:0] HIGH3 = CAR_CNT_WIDTH'(CAR3_PERIOD >> 1);
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state_q, state_d;
  logic [PACK_CNT_WIDTH-1:0] pCnt_q, pCnt_d;
  logic [CAR_CNT_WIDTH-1:0]  cCnt_q, cCnt_d;
  logic [1:0]                carId_q, carId_d;
  logic [3:0]                dir_q, dir_d;
  logic                      pulse_q, pulse_d;
  logic                      cStb_q, cStb_d;
  logic                      pStb_q, pStb_d;
  logic                      packStart;
  logic [CAR_CNT_WIDTH-1:0]  curLast;
  logic [CAR_CNT_WIDTH-1:0]  nextHigh;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      pCnt_q  <= '0;
      cCnt_q  <= '0;
      carId_q <= '0;
      dir_q   <= '0;
      pulse_q <= 1'b0;
      cStb_q  <= 1'b0;
      pStb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pCnt_q  <= pCnt_d;
      cCnt_q  <= cCnt_d;
      carId_q <= carId_d;
      dir_q   <= dir_d;
      pulse_q <= pulse_d;
      cStb_q  <= cStb_d;
      pStb_q  <= pStb_d;
    end
  end

  // Outputs are registered from the next counter values, so they line up with the counters.
  always_comb begin
    state_d   = IDLE;
    pCnt_d    = '0;
    cCnt_d    = '0;
    carId_d   = carId_q;
    dir_d     = dir_q;
    packStart = 1'b0;
    unique case (carId_q)
      2'd0:    curLast = LAST0;
      2'd1:    curLast = LAST1;
      2'd2:    curLast = LAST2;
      default: curLast = LAST3;
    endcase
    if (en) begin
      state_d = RUN;
      if (state_q == IDLE || pCnt_q == PACK_LAST) begin
        packStart = 1'b1;
        carId_d   = car_sel;
        dir_d     = dir_in;
      end else begin
        pCnt_d = pCnt_q + 1'b1;
        cCnt_d = (cCnt_q == curLast) ? '0 : cCnt_q + 1'b1;
      end
    end
    unique case (carId_d)
      2'd0:    nextHigh = HIGH0;
      2'd1:    nextHigh = HIGH1;
      2'd2:    nextHigh = HIGH2;
      default: nextHigh = HIGH3;
    endcase
    pStb_d  = packStart;
    cStb_d  = (state_d == RUN) && (cCnt_d == '0);
    pulse_d = (state_d == RUN) && (cCnt_d < nextHigh);
  end

  assign Pulse             = pulse_q;
  assign Pulse_Strobe      = cStb_q;
  assign pack_strobe       = pStb_q;
  assign current_dir_state = dir_q;
  assign car_id            = carId_q;

endmodule

// File: tb/tb_ir_carrier_gen.sv
// Bench for ir_carrier_gen: directed vector table, hand sequences and a randomized run
// checked against a cycle-arithmetic reference model (honours IR_CARRIER_DUTY33_EN).
module tb_ir_carrier_gen;
  localparam int C0 = 10, C1 = 12, C2 = 14, C3 = 16, PACK = 100;

  logic       CLK = 1'b0;
  logic       RST, en;
  logic [1:0] car_sel;
  logic [3:0] dir_in;
  logic       Pulse, Pulse_Strobe, pack_strobe;
  logic [3:0] current_dir_state;
  logic [1:0] car_id;

  always #5 CLK = ~CLK;

  ir_carrier_gen #(
    .CAR0_PERIOD(C0), .CAR1_PERIOD(C1), .CAR2_PERIOD(C2), .CAR3_PERIOD(C3),
    .CAR_CNT_WIDTH(12), .PACK_PERIOD(PACK), .PACK_CNT_WIDTH(24)
  ) dut (
    .CLK(CLK), .RST(RST), .en(en), .car_sel(car_sel), .dir_in(dir_in),
    .Pulse(Pulse), .Pulse_Strobe(Pulse_Strobe), .pack_strobe(pack_strobe),
    .current_dir_state(current_dir_state), .car_id(car_id)
  );

  int compared = 0, mismatched = 0;
  int n = 0;
  bit mRun = 0;
  int mPkt = 0;
  logic [1:0] mId = 2'd0;
  logic [3:0] mDir = 4'd0;

  typedef struct {
    logic rst, en; logic [1:0] sel; logic [3:0] dir;
    logic pulse, ps, pk; logic [3:0] dirE; logic [1:0] idE;
  } vec_t;
  vec_t vecs[10];

  function automatic int periodOf(input logic [1:0] s);
    case (s)
      2'd0: return C0;
      2'd1: return C1;
      2'd2: return C2;
      default: return C3;
    endcase
  endfunction

  function automatic int highOf(input logic [1:0] s);
`ifdef IR_CARRIER_DUTY33_EN
    return periodOf(s) / 3;
`else
    return periodOf(s) / 2;
`endif
  endfunction

  task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic eP, input logic ePs, input logic ePk,
                             input logic [3:0] eD, input logic [1:0] eI);
    checkOne({tag, ".Pulse"}, 32'(Pulse), 32'(eP));
    checkOne({tag, ".Pulse_Strobe"}, 32'(Pulse_Strobe), 32'(ePs));
    checkOne({tag, ".pack_strobe"}, 32'(pack_strobe), 32'(ePk));
    checkOne({tag, ".dir"}, 32'(current_dir_state), 32'(eD));
    checkOne({tag, ".car_id"}, 32'(car_id), 32'(eI));
  endtask

  // Reference: a packet starts when enabled from idle or PACK cycles after the last start;
  // within a packet the carrier phase is simply (cycles since packet start) mod P.
  task automatic modelEdge();
    if (!RST) begin
      mRun = 0; mId = 2'd0; mDir = 4'd0;
    end else if (!en) begin
      mRun = 0;
    end else if (!mRun || (n - mPkt) >= PACK) begin
      mRun = 1; mPkt = n; mId = car_sel; mDir = dir_in;
    end
  endtask

  task automatic checkModel(input string tag);
    int k, c;
    if (mRun) begin
      k = n - mPkt;
      c = k % periodOf(mId);
      checkOutput(tag, c < highOf(mId), c == 0, k == 0, mDir, mId);
    end else begin
      checkOutput(tag, 1'b0, 1'b0, 1'b0, mDir, mId);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [1:0] s, input logic [3:0] d);
    RST = r; en = e; car_sel = s; dir_in = d;
    @(posedge CLK);
    n++;
    modelEdge();
    #1;
  endtask

  initial begin
    int hiCount;
    logic enState;
    RST = 1'b0; en = 1'b0; car_sel = 2'd0; dir_in = 4'd0;

    vecs[0] = '{1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0};
    vecs[1] = '{1'b0, 1'b1, 2'd3, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0};
    vecs[2] = '{1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0};
    vecs[3] = '{1'b1, 1'b1, 2'd2, 4'h9, 1'b1, 1'b1, 1'b1, 4'h9, 2'd2};
    vecs[4] = '{1'b1, 1'b1, 2'd0, 4'h6, 1'b1, 1'b0, 1'b0, 4'h9, 2'd2};
    vecs[5] = '{1'b1, 1'b0, 2'd0, 4'h6, 1'b0, 1'b0, 1'b0, 4'h9, 2'd2};
    vecs[6] = '{1'b1, 1'b1, 2'd1, 4'h3, 1'b1, 1'b1, 1'b1, 4'h3, 2'd1};
    vecs[7] = '{1'b1, 1'b1, 2'd0, 4'hC, 1'b1, 1'b0, 1'b0, 4'h3, 2'd1};
    vecs[8] = '{1'b0, 1'b1, 2'd0, 4'hC, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0};
    vecs[9] = '{1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0};

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].sel, vecs[i].dir);
      checkOutput($sformatf("vec%0d", i), vecs[i].pulse, vecs[i].ps, vecs[i].pk, vecs[i].dirE, vecs[i].idE);
    end

    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b1, 1'b0, 2'd2, 4'h9);
      checkOutput("idle", 1'b0, 1'b0, 1'b0, 4'h0, 2'd0);
    end

    // Start car 2, measure one carrier period, then swap request mid-packet.
    applyStimulus(1'b1, 1'b1, 2'd2, 4'h9);
    checkOutput("start", 1'b1, 1'b1, 1'b1, 4'h9, 2'd2);
    hiCount = int'(Pulse);
    for (int k = 1; k < 14; k++) begin
      applyStimulus(1'b1, 1'b1, 2'd2, 4'h9);
      checkModel("periodA");
      hiCount += int'(Pulse);
    end
    checkOne("duty_high", 32'(hiCount), 32'(highOf(2'd2)));
    for (int k = 14; k < 100; k++) begin
      if (k < 30) applyStimulus(1'b1, 1'b1, 2'd2, 4'h9);
      else        applyStimulus(1'b1, 1'b1, 2'd0, 4'h6);
      if (k == 14) checkOne("second_carrier_strobe", 32'(Pulse_Strobe), 32'd1);
      checkModel("hold");
    end
    applyStimulus(1'b1, 1'b1, 2'd0, 4'h6);
    checkOutput("boundary", 1'b1, 1'b1, 1'b1, 4'h6, 2'd0);
    applyStimulus(1'b1, 1'b1, 2'd0, 4'h6);
    checkOutput("after_boundary", 1'b1, 1'b0, 1'b0, 4'h6, 2'd0);
    for (int k = 102; k < 157; k++) begin
      applyStimulus(1'b1, 1'b1, 2'd1, 4'h2);
      checkModel("runB");
    end
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0, 2'd1, 4'h2);
      checkOutput("disabled", 1'b0, 1'b0, 1'b0, 4'h6, 2'd0);
    end
    applyStimulus(1'b0, 1'b0, 2'd1, 4'h2);
    checkOutput("reset_clear", 1'b0, 1'b0, 1'b0, 4'h0, 2'd0);
    applyStimulus(1'b1, 1'b1, 2'd3, 4'h5);
    checkOutput("reenable", 1'b1, 1'b1, 1'b1, 4'h5, 2'd3);

    enState = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) enState = ~enState;
      applyStimulus($urandom_range(0, 499) != 0, enState, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      checkModel("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
